// File: rtl/control_sequencer.sv
// Microcoded control sequencer for a 4-bit bus computer: six-step fetch/execute
// counter with a sticky halt state; control lines decode combinationally from state.
module control_sequencer (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       jmp,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       sub,
    output logic       flag_in,
    output logic       out_in,
    output logic       hlt,
    output logic [2:0] step
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned STEP_W = 3;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_STA = 4'b0100;
    localparam logic [OP_W-1:0] OP_LDI = 4'b0101;
    localparam logic [OP_W-1:0] OP_JMP = 4'b0110;
    localparam logic [OP_W-1:0] OP_JC  = 4'b0111;
    localparam logic [OP_W-1:0] OP_JZ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5
    } step_e;

    step_e state_q, state_d;
    logic  halted_q, halted_d;

    // State register; clear aborts any instruction in flight
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next-step sequencing and control decode; everything gated off while clear is low
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        jmp      = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ram_in   = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        sub      = 1'b0;
        flag_in  = 1'b0;
        out_in   = 1'b0;
        hlt      = clear & halted_q;
        step     = clear ? STEP_W'(state_q) : '0;

        if (!halted_q) begin
            case (state_q)
                T0: begin
                    state_d = T1;
                    pc_out  = clear;
                    mar_in  = clear;
                end
                T1: begin
                    state_d = T2;
                    ram_out = clear;
                    ir_in   = clear;
                    pc_inc  = clear;
                end
                T2: begin
                    state_d = T0;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            state_d = T3;
                            ir_out  = clear;
                            mar_in  = clear;
                        end
                        OP_LDI: begin
                            ir_out = clear;
                            a_in   = clear;
                        end
                        OP_JMP: begin
                            ir_out = clear;
                            jmp    = clear;
                        end
                        OP_JC: begin
                            ir_out = clear & carry_flag;
                            jmp    = clear & carry_flag;
                        end
                        OP_JZ: begin
                            ir_out = clear & zero_flag;
                            jmp    = clear & zero_flag;
                        end
                        OP_OUT: begin
                            a_out  = clear;
                            out_in = clear;
                        end
                        OP_HLT: begin
                            state_d  = T2;
                            halted_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    state_d = T0;
                    case (opcode)
                        OP_LDA: begin
                            ram_out = clear;
                            a_in    = clear;
                        end
                        OP_ADD, OP_SUB: begin
                            state_d = T4;
                            ram_out = clear;
                            b_in    = clear;
                        end
                        OP_STA: begin
                            a_out  = clear;
                            ram_in = clear;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    state_d = T0;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out = clear;
                        a_in    = clear;
                        flag_in = clear;
                        sub     = clear & (opcode == OP_SUB);
                    end
                end
                // T5 is reserved: fall back to fetch with nothing asserted
                default: state_d = T0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction walks plus randomized opcodes/flags
// checked against a per-instruction microcode table model.
module tb_control_sequencer;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic pc_out, pc_inc, jmp, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, sub, flag_in, out_in, hlt;
    logic [2:0] step;

    int checks = 0;
    int errors = 0;
    int m_step = 0;
    bit m_halt = 1'b0;

    localparam logic [15:0] C_PC_OUT  = 16'h8000;
    localparam logic [15:0] C_PC_INC  = 16'h4000;
    localparam logic [15:0] C_JMP     = 16'h2000;
    localparam logic [15:0] C_MAR_IN  = 16'h1000;
    localparam logic [15:0] C_RAM_OUT = 16'h0800;
    localparam logic [15:0] C_RAM_IN  = 16'h0400;
    localparam logic [15:0] C_IR_IN   = 16'h0200;
    localparam logic [15:0] C_IR_OUT  = 16'h0100;
    localparam logic [15:0] C_A_IN    = 16'h0080;
    localparam logic [15:0] C_A_OUT   = 16'h0040;
    localparam logic [15:0] C_B_IN    = 16'h0020;
    localparam logic [15:0] C_ALU_OUT = 16'h0010;
    localparam logic [15:0] C_SUB     = 16'h0008;
    localparam logic [15:0] C_FLAG_IN = 16'h0004;
    localparam logic [15:0] C_OUT_IN  = 16'h0002;
    localparam logic [15:0] C_HLT     = 16'h0001;

    logic [15:0] obs;
    logic [4:0]  drivers;
    assign obs = {pc_out, pc_inc, jmp, mar_in, ram_out, ram_in, ir_in, ir_out,
                  a_in, a_out, b_in, alu_out, sub, flag_in, out_in, hlt};
    assign drivers = {pc_out, ram_out, ir_out, a_out, alu_out};

    control_sequencer dut (
        .clock(clock), .clear(clear), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_out(pc_out), .pc_inc(pc_inc), .jmp(jmp), .mar_in(mar_in),
        .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
        .sub(sub), .flag_in(flag_in), .out_in(out_in), .hlt(hlt), .step(step)
    );

    always #5 clock = ~clock;

    // Final time step of each instruction
    function automatic int last_step(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 3;
            4'h2, 4'h3: return 4;
            default:    return 2;
        endcase
    endfunction

    // Microcode table: control set for a given step of a given instruction
    function automatic logic [15:0] exp_ctl(input int st, input bit h, input logic [3:0] op,
                                            input logic c, input logic z);
        if (h) return C_HLT;
        case (st)
            0: return C_PC_OUT | C_MAR_IN;
            1: return C_RAM_OUT | C_IR_IN | C_PC_INC;
            2: case (op)
                   4'h1, 4'h2, 4'h3, 4'h4: return C_IR_OUT | C_MAR_IN;
                   4'h5: return C_IR_OUT | C_A_IN;
                   4'h6: return C_IR_OUT | C_JMP;
                   4'h7: return c ? (C_IR_OUT | C_JMP) : 16'h0000;
                   4'h8: return z ? (C_IR_OUT | C_JMP) : 16'h0000;
                   4'hE: return C_A_OUT | C_OUT_IN;
                   default: return 16'h0000;
               endcase
            3: case (op)
                   4'h1: return C_RAM_OUT | C_A_IN;
                   4'h2, 4'h3: return C_RAM_OUT | C_B_IN;
                   4'h4: return C_A_OUT | C_RAM_IN;
                   default: return 16'h0000;
               endcase
            4: case (op)
                   4'h2: return C_ALU_OUT | C_A_IN | C_FLAG_IN;
                   4'h3: return C_ALU_OUT | C_A_IN | C_FLAG_IN | C_SUB;
                   default: return 16'h0000;
               endcase
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e_ctl;
        int e_step;
        e_ctl  = clear ? exp_ctl(m_step, m_halt, opcode, carry_flag, zero_flag) : 16'h0000;
        e_step = !clear ? 0 : (m_halt ? 2 : m_step);
        chk({tag, "_ctl"}, obs, e_ctl);
        chk({tag, "_step"}, 16'(step), 16'(e_step));
        chk({tag, "_onebus"}, 16'($countones(drivers) <= 1), 16'd1);
        chk({tag, "_incjmp"}, 16'(pc_inc & jmp), 16'd0);
    endtask

    // Model reaction to a rising edge, using inputs as they stand at that edge
    task automatic model_edge();
        if (!clear) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_step == 2 && opcode == 4'hF) begin
            m_halt = 1'b1;
        end else if (m_step >= last_step(opcode)) begin
            m_step = 0;
        end else begin
            m_step = m_step + 1;
        end
    endtask

    // Called just after a rising edge with inputs already driven
    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input logic c, input logic z);
        opcode = op;
        carry_flag = c;
        zero_flag = z;
        do cyc(tag); while (m_step != 0);
    endtask

    initial begin
        #1;
        check_all("reset");
        cyc("reset_clk");
        cyc("reset_clk");
        clear = 1'b1;

        run_instr("lda", 4'h1, 1'b0, 1'b0);
        chk("lda_back_t0", 16'(step), 16'd0);
        run_instr("sub", 4'h3, 1'b1, 1'b0);
        run_instr("add", 4'h2, 1'b0, 1'b1);
        run_instr("jc_nc", 4'h7, 1'b0, 1'b1);
        run_instr("jc_c", 4'h7, 1'b1, 1'b0);
        run_instr("jz_z", 4'h8, 1'b0, 1'b1);
        run_instr("sta", 4'h4, 1'b0, 1'b0);
        run_instr("ldi", 4'h5, 1'b0, 1'b0);
        run_instr("jmp", 4'h6, 1'b0, 1'b0);
        run_instr("out", 4'hE, 1'b0, 1'b0);
        run_instr("nop", 4'h0, 1'b1, 1'b1);
        run_instr("undef", 4'hA, 1'b0, 1'b0);

        // Halt: sticky for many cycles even with inputs wiggling
        opcode = 4'hF;
        for (int i = 0; i < 3; i++) cyc("hlt_fetch");
        for (int i = 0; i < 22; i++) begin
            opcode = 4'($urandom);
            carry_flag = 1'($urandom);
            cyc("hlt_hold");
        end
        chk("hlt_pin", 16'(hlt), 16'd1);
        #2;
        clear = 1'b0;
        m_step = 0;
        m_halt = 1'b0;
        #1;
        check_all("hlt_clear");
        @(posedge clock);
        model_edge();
        #1;
        clear = 1'b1;
        #1;
        chk("hlt_release_hlt", 16'(hlt), 16'd0);

        // Abort an ADD in T3 asynchronously
        opcode = 4'h2;
        while (m_step != 3) cyc("add_pre");
        #1;
        check_all("add_t3");
        #2;
        clear = 1'b0;
        m_step = 0;
        m_halt = 1'b0;
        #1;
        check_all("abort_async");
        chk("abort_bus", obs, 16'h0000);
        @(posedge clock);
        model_edge();
        #1;
        check_all("abort_held");
        #2;
        clear = 1'b1;
        #1;
        check_all("abort_release_t0");
        @(posedge clock);
        model_edge();
        #1;
        run_instr("add_after_abort", 4'h2, 1'b0, 1'b0);

        // Random opcodes and flags; opcode only changes at instruction boundaries
        for (int i = 0; i < 10000; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) begin
                clear = 1'b0;
                m_step = 0;
                m_halt = 1'b0;
                cyc("rand_clear");
                clear = 1'b1;
            end else begin
                if (m_step == 0 && !m_halt) begin
                    opcode = 4'($urandom);
                    if (opcode == 4'hF && $urandom_range(0, 3) != 0) opcode = 4'h0;
                end
                carry_flag = 1'($urandom);
                zero_flag = 1'($urandom);
                cyc("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
